// File: rtl/cipo_pkg.sv
// cipo_pkg
//   Shared geometry for CIPO word recovery from a 4x-oversampled capture.
//   OVERSAMPLE   : master-clock samples per SCLK period
//   WORD_BITS    : bits per DDR register half (A or B)
//   CAPTURE_BITS : length of one oversampled capture
//   DDR_OFFSET   : sample offset of the falling (B) edge within a period
//   MAX_PHASE    : largest usable phase; keeps every pick index <= 73
package cipo_pkg;

  localparam int OVERSAMPLE   = 4;
  localparam int WORD_BITS    = 16;
  localparam int CAPTURE_BITS = 74;
  localparam int DDR_OFFSET   = 2;
  localparam int MAX_PHASE    = 11;

  typedef logic [CAPTURE_BITS-1:0] capture_t;
  typedef logic [2*WORD_BITS-1:0]  word_t;

  // Saturate the requested phase so 12..15 behave exactly like 11.
  function automatic logic [3:0] clamp_phase(input logic [3:0] phase_req);
    logic [3:0] phase_v;
    if (phase_req > 4'(MAX_PHASE)) begin
      phase_v = 4'(MAX_PHASE);
    end else begin
      phase_v = phase_req;
    end
    return phase_v;
  endfunction

endpackage

// File: rtl/cipo_ddr_bit_picker.sv
// cipo_ddr_bit_picker
//   Combinational 16-way selector: picks one sample per SCLK period out of
//   the oversampled capture, MSB (period 0) first.
//   capture     in  74  oversampled capture
//   phase       in  4   already-clamped phase (0..11)
//   edge_offset in  2   0 for the rising (A) edge, 2 for the falling (B) edge
//   bits        out 16  recovered half-word, bits[15] = period 0
module cipo_ddr_bit_picker
  import cipo_pkg::*;
(
  input  capture_t               capture,
  input  logic [3:0]             phase,
  input  logic [1:0]             edge_offset,
  output logic [WORD_BITS-1:0]   bits
);

  // Period k takes sample OVERSAMPLE*k + edge_offset + phase.
  always_comb begin
    bits = '0;
    for (int k = 0; k < WORD_BITS; k++) begin
      logic [6:0] idx_v;
      idx_v = 7'(OVERSAMPLE * k) + 7'(edge_offset) + 7'(phase);
      bits[WORD_BITS-1-k] = capture[idx_v];
    end
  end

endmodule

// File: rtl/cipo_combined_phase_selector.sv
// cipo_combined_phase_selector
//   Recovers one 32-bit DDR CIPO word (A on SCLK rising, B on falling) from a
//   74-sample 4x-oversampled capture, with programmable cable-delay phase.
//   clk          in  1   master clock (4x SCLK)
//   rstn         in  1   asynchronous active-low reset
//   phase_select in  4   cable-delay compensation in samples (12..15 act as 11)
//   CIPO4x       in  74  oversampled capture, bit 0 aligned to first SCLK rise
//   CIPO         out 32  registered word: [15:0] = A, [31:16] = B, MSB first
module cipo_combined_phase_selector
  import cipo_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] phase_select,
  input  capture_t   CIPO4x,
  output word_t      CIPO
);

  logic [3:0]           phase_s;
  logic [WORD_BITS-1:0] reg_a_s;
  logic [WORD_BITS-1:0] reg_b_s;

  // Clamp the requested phase to the last index-safe value.
  always_comb begin
    phase_s = clamp_phase(phase_select);
  end

  cipo_ddr_bit_picker u_pick_a (
    .capture     (CIPO4x),
    .phase       (phase_s),
    .edge_offset (2'd0),
    .bits        (reg_a_s)
  );

  cipo_ddr_bit_picker u_pick_b (
    .capture     (CIPO4x),
    .phase       (phase_s),
    .edge_offset (2'(DDR_OFFSET)),
    .bits        (reg_b_s)
  );

  // Output register: one clock of latency, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      CIPO <= 32'h0000_0000;
    end else begin
      CIPO <= {reg_b_s, reg_a_s};
    end
  end

endmodule

// File: tb/tb_cipo_combined_phase_selector.sv
module tb_cipo_combined_phase_selector;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  phase_select;
  logic [73:0] cipo4x;
  logic [31:0] cipo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_exp = 32'd0;

  always #5 clk = ~clk;

  cipo_combined_phase_selector dut (
    .clk          (clk),
    .rstn         (rstn),
    .phase_select (phase_select),
    .CIPO4x       (cipo4x),
    .CIPO         (cipo)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: index formula with saturated phase.
  function automatic logic [31:0] ref_word(input logic [73:0] cap, input logic [3:0] ps);
    int p;
    logic [31:0] w;
    p = (ps > 4'd11) ? 11 : int'(ps);
    w = 32'd0;
    for (int k = 0; k < 16; k++) begin
      w[5'(15 - k)] = cap[7'(4 * k + p)];
      w[5'(31 - k)] = cap[7'(4 * k + 2 + p)];
    end
    return w;
  endfunction

  function automatic logic [73:0] rand_cap();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[73:0];
  endfunction

  // Called just after a rising edge: drive, confirm the output holds until
  // the next edge, then check the new word one clock later.
  task automatic apply(input logic [3:0] ps, input logic [73:0] cap, input string tag);
    phase_select = ps;
    cipo4x       = cap;
    #1;
    check_eq({tag, "_hold"}, cipo, prev_exp);
    @(posedge clk);
    #1;
    prev_exp = ref_word(cap, ps);
    check_eq(tag, cipo, prev_exp);
  endtask

  initial begin
    logic [73:0] cap;
    logic [73:0] rc;

    // Reset with arbitrary inputs.
    rstn         = 1'b0;
    phase_select = 4'($urandom_range(0, 15));
    cipo4x       = rand_cap();
    #2;
    check_eq("reset_async", cipo, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("reset_held", cipo, 32'd0);
    #2;
    rstn = 1'b1;
    #1;
    check_eq("reset_release_pre_edge", cipo, 32'd0);
    @(posedge clk);
    #1;
    prev_exp = ref_word(cipo4x, phase_select);
    check_eq("first_edge_after_reset", cipo, prev_exp);

    // Phase 0, rising-edge samples set.
    cap = '0;
    for (int k = 0; k < 16; k++) cap[7'(4 * k)] = 1'b1;
    apply(4'd0, cap, "p0_a_all");
    check_eq("p0_a_const", cipo, 32'h0000_FFFF);
    cap = '0;
    for (int k = 0; k < 16; k++) cap[7'(4 * k + 2)] = 1'b1;
    apply(4'd0, cap, "p0_b_all");
    check_eq("p0_b_const", cipo, 32'hFFFF_0000);

    // Phase 3 single bits.
    cap = '0; cap[3] = 1'b1;
    apply(4'd3, cap, "p3_bit3");
    check_eq("p3_bit3_const", cipo, 32'h0000_8000);
    cap = '0; cap[5] = 1'b1;
    apply(4'd3, cap, "p3_bit5");
    check_eq("p3_bit5_const", cipo, 32'h8000_0000);

    // Phase 11 top boundary.
    cap = '0; cap[73] = 1'b1;
    apply(4'd11, cap, "p11_bit73");
    check_eq("p11_bit73_const", cipo, 32'h0001_0000);
    cap = '0; cap[71] = 1'b1;
    apply(4'd11, cap, "p11_bit71");
    check_eq("p11_bit71_const", cipo, 32'h0000_0001);

    // Clamp: 12..15 must equal 11 on the same capture.
    for (int i = 0; i < 8; i++) begin
      rc = rand_cap();
      apply(4'd15, rc, "clamp15");
      check_eq("clamp15_vs_p11", cipo, ref_word(rc, 4'd11));
      apply(4'(12 + (i % 4)), rc, "clamp12_15");
      apply(4'd11, rc, "clamp11");
    end

    // Random sweep: every phase, 1000 captures each.
    for (int ph = 0; ph < 16; ph++) begin
      for (int n = 0; n < 1000; n++) begin
        apply(4'(ph), rand_cap(), "sweep");
      end
    end

    // Phase changing every clock.
    for (int n = 0; n < 200; n++) begin
      apply(4'($urandom_range(0, 15)), rand_cap(), "phase_hop");
    end

    // Reset mid-operation clears immediately, first edge reloads.
    rstn = 1'b0;
    #1;
    check_eq("midop_reset_async", cipo, 32'd0);
    @(posedge clk);
    #1;
    check_eq("midop_reset_held", cipo, 32'd0);
    rstn     = 1'b1;
    prev_exp = 32'd0;
    apply(4'd7, rand_cap(), "post_midop_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
